pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master: the pipeline side (drives hazard sources, receives stall/flush).
// slave:  the hazard controller.
interface pipe_hazard_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        ex_branch_taken;
  logic        ex_mc_start;
  logic        mc_done;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write,
    output ex_branch_taken, ex_mc_start, mc_done,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    input  state, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write,
    input  ex_branch_taken, ex_mc_start, mc_done,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    output state, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data hazards (bubble via LU), taken branches
// (FLUSH) and multi-cycle ops (MC_WAIT freeze), plus a saturating stall counter.
// Build option: define HAZ_FORWARD_EN when the datapath has full forwarding,
// so only load-use against EX needs a stall; otherwise EX and MEM producers
// both stall the ID instruction.
module pipe_hazard_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_if.slave      bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU      = 2'd1,
    FLUSH   = 2'd2,
    MC_WAIT = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] stall_cnt_reg;
  logic        hz_rs1, hz_rs2, hz;
  logic        pc_stall_next, if_id_stall_next, if_id_flush_next;
  logic        id_ex_stall_next, id_ex_flush_next;

  // Does a source operand depend on a producer that cannot forward in time.
  function automatic logic src_hazard(input logic [4:0] rs, input logic use_rs,
                                      input logic [4:0] ex_rd, input logic ex_wr,
                                      input logic ex_load, input logic [4:0] mem_rd,
                                      input logic mem_wr);
    logic dep;
`ifdef HAZ_FORWARD_EN
    dep = (rs == ex_rd) && ex_wr && ex_load;
`else
    dep = ((rs == ex_rd) && ex_wr) || ((rs == mem_rd) && mem_wr);
`endif
    return use_rs && (rs != 5'd0) && dep;
  endfunction

  assign hz_rs1 = src_hazard(bus.id_rs1, bus.id_use_rs1, bus.ex_rd, bus.ex_reg_write,
                             bus.ex_mem_read, bus.mem_rd, bus.mem_reg_write);
  assign hz_rs2 = src_hazard(bus.id_rs2, bus.id_use_rs2, bus.ex_rd, bus.ex_reg_write,
                             bus.ex_mem_read, bus.mem_rd, bus.mem_reg_write);
  assign hz     = hz_rs1 || hz_rs2;

  // State register; reset returns to RUN immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RUN;
    else        state_reg <= state_next;
  end

  // Next state and control outputs from current state and hazard sources.
  always_comb begin
    state_next       = state_reg;
    pc_stall_next    = 1'b0;
    if_id_stall_next = 1'b0;
    if_id_flush_next = 1'b0;
    id_ex_stall_next = 1'b0;
    id_ex_flush_next = 1'b0;
    case (state_reg)
      RUN: begin
        if (bus.ex_branch_taken) begin
          if_id_flush_next = 1'b1;
          id_ex_flush_next = 1'b1;
          state_next       = FLUSH;
        end else if (bus.ex_mc_start) begin
          // An op that finishes in its start cycle needs no freeze.
          if (!bus.mc_done) begin
            pc_stall_next    = 1'b1;
            if_id_stall_next = 1'b1;
            id_ex_stall_next = 1'b1;
            state_next       = MC_WAIT;
          end else begin
            state_next = RUN;
          end
        end else if (hz) begin
          pc_stall_next    = 1'b1;
          if_id_stall_next = 1'b1;
          id_ex_flush_next = 1'b1;
          state_next       = LU;
        end else begin
          state_next = RUN;
        end
      end
      LU: begin
        if (bus.ex_branch_taken) begin
          if_id_flush_next = 1'b1;
          id_ex_flush_next = 1'b1;
          state_next       = FLUSH;
        end else if (hz) begin
          pc_stall_next    = 1'b1;
          if_id_stall_next = 1'b1;
          id_ex_flush_next = 1'b1;
          state_next       = LU;
        end else begin
          state_next = RUN;
        end
      end
      FLUSH: begin
        // EX holds a bubble this cycle, so only a new branch matters.
        if (bus.ex_branch_taken) begin
          if_id_flush_next = 1'b1;
          id_ex_flush_next = 1'b1;
          state_next       = FLUSH;
        end else begin
          state_next = RUN;
        end
      end
      MC_WAIT: begin
        // The whole front end is frozen; branches and hazards cannot advance.
        if (bus.mc_done) begin
          state_next = RUN;
        end else begin
          pc_stall_next    = 1'b1;
          if_id_stall_next = 1'b1;
          id_ex_stall_next = 1'b1;
          state_next       = MC_WAIT;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Stall cycle counter, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_reg <= 16'd0;
    else if (pc_stall_next && (stall_cnt_reg != 16'hFFFF))
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  // Outputs are forced low for the whole time reset is asserted.
  assign bus.pc_stall    = rst_n && pc_stall_next;
  assign bus.if_id_stall = rst_n && if_id_stall_next;
  assign bus.if_id_flush = rst_n && if_id_flush_next;
  assign bus.id_ex_stall = rst_n && id_ex_stall_next;
  assign bus.id_ex_flush = rst_n && id_ex_flush_next;
  assign bus.state       = state_reg;
  assign bus.stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random
// traffic, compared each cycle with a rule-level reference model.
`timescale 1ns/100ps
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rst_n;
  pipe_hazard_if bus ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_mode = 0;   // 0 running, 1 load-use wait, 2 after flush, 3 multicycle wait
  int m_cnt  = 0;

  localparam int ACT_NONE = 0, ACT_FLUSH = 1, ACT_FREEZE = 2, ACT_BUBBLE = 3;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit operand_waits(input logic [4:0] rs, input logic use_rs);
    if (!use_rs || rs == 5'd0) return 1'b0;
`ifdef HAZ_FORWARD_EN
    return (rs == bus.ex_rd) && bus.ex_reg_write && bus.ex_mem_read;
`else
    return ((rs == bus.ex_rd) && bus.ex_reg_write) || ((rs == bus.mem_rd) && bus.mem_reg_write);
`endif
  endfunction

  task automatic idle_inputs();
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.ex_rd = 0; bus.ex_reg_write = 0; bus.ex_mem_read = 0;
    bus.mem_rd = 0; bus.mem_reg_write = 0;
    bus.ex_branch_taken = 0; bus.ex_mc_start = 0; bus.mc_done = 0;
  endtask

  // Inputs are already driven (posedge+1). Check at posedge+3, then advance.
  task automatic step(input string tag);
    bit hz;
    int act;
    int nxt;
    bit e_stall;
    #2;
    hz  = operand_waits(bus.id_rs1, bus.id_use_rs1) || operand_waits(bus.id_rs2, bus.id_use_rs2);
    act = ACT_NONE;
    nxt = 0;
    if (m_mode == 3) begin
      if (!bus.mc_done) begin act = ACT_FREEZE; nxt = 3; end
    end else if (bus.ex_branch_taken) begin
      act = ACT_FLUSH; nxt = 2;
    end else if (m_mode == 0 && bus.ex_mc_start) begin
      if (!bus.mc_done) begin act = ACT_FREEZE; nxt = 3; end
    end else if (m_mode != 2 && hz) begin
      act = ACT_BUBBLE; nxt = 1;
    end
    e_stall = (act == ACT_FREEZE) || (act == ACT_BUBBLE);
    check({tag, ".state"},       16'(bus.state), 16'(m_mode));
    check({tag, ".stall_cnt"},   bus.stall_cnt, 16'(m_cnt));
    check({tag, ".pc_stall"},    16'(bus.pc_stall), 16'(e_stall));
    check({tag, ".if_id_stall"}, 16'(bus.if_id_stall), 16'(e_stall));
    check({tag, ".if_id_flush"}, 16'(bus.if_id_flush), 16'(act == ACT_FLUSH));
    check({tag, ".id_ex_stall"}, 16'(bus.id_ex_stall), 16'(act == ACT_FREEZE));
    check({tag, ".id_ex_flush"}, 16'(bus.id_ex_flush),
          16'((act == ACT_FLUSH) || (act == ACT_BUBBLE)));
    $display("step %s mode=%0d act=%0d cnt=%0d", tag, m_mode, act, m_cnt);
    @(posedge clk);
    m_mode = nxt;
    if (e_stall && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    // Hazard sources active during reset must not reach the outputs.
    bus.ex_mc_start = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 5'd7;
    bus.ex_rd = 5'd7; bus.ex_reg_write = 1; bus.ex_mem_read = 1;
    #12;
    check("reset.pc_stall",    16'(bus.pc_stall), 16'd0);
    check("reset.id_ex_stall", 16'(bus.id_ex_stall), 16'd0);
    check("reset.id_ex_flush", 16'(bus.id_ex_flush), 16'd0);
    check("reset.state",       16'(bus.state), 16'd0);
    check("reset.stall_cnt",   bus.stall_cnt, 16'd0);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use on rs1 against a load in EX, then the load moves to MEM.
    bus.ex_rd = 5; bus.ex_reg_write = 1; bus.ex_mem_read = 1;
    bus.id_rs1 = 5; bus.id_use_rs1 = 1;
    step("load_ex");
    bus.ex_rd = 0; bus.ex_reg_write = 0; bus.ex_mem_read = 0;
    bus.mem_rd = 5; bus.mem_reg_write = 1;
    step("load_mem");
    idle_inputs();
    step("load_done");

    // ALU producer of r3 read via rs2: EX match, then MEM match.
    bus.ex_rd = 3; bus.ex_reg_write = 1; bus.id_rs2 = 3; bus.id_use_rs2 = 1;
    step("alu_ex");
    bus.ex_rd = 0; bus.ex_reg_write = 0; bus.mem_rd = 3; bus.mem_reg_write = 1;
    step("alu_mem");
    idle_inputs();
    step("alu_done");

    // Branch together with an active hazard: flush wins.
    bus.ex_rd = 9; bus.ex_reg_write = 1; bus.ex_mem_read = 1;
    bus.id_rs1 = 9; bus.id_use_rs1 = 1; bus.ex_branch_taken = 1;
    step("br_hz");
    bus.ex_branch_taken = 0;
    step("br_flush");
    idle_inputs();
    step("br_run");

    // Multi-cycle op, done four cycles later, branch pulse ignored meanwhile.
    bus.ex_mc_start = 1;
    step("mc_start");
    bus.ex_mc_start = 0;
    step("mc_w1");
    bus.ex_branch_taken = 1;
    step("mc_w2_br");
    bus.ex_branch_taken = 0;
    step("mc_w3");
    bus.mc_done = 1;
    step("mc_done");
    bus.mc_done = 0;
    step("mc_after");

    // Zero-wait multi-cycle op.
    bus.ex_mc_start = 1; bus.mc_done = 1;
    step("mc_zero");
    idle_inputs();
    step("mc_zero_after");

    // Asynchronous reset pulse in the middle of a multi-cycle wait.
    bus.ex_mc_start = 1;
    step("rst_mc_start");
    bus.ex_mc_start = 0;
    step("rst_mc_w1");
    rst_n = 1'b0;
    #0.5;
    check("arst.pc_stall",    16'(bus.pc_stall), 16'd0);
    check("arst.if_id_stall", 16'(bus.if_id_stall), 16'd0);
    check("arst.id_ex_stall", 16'(bus.id_ex_stall), 16'd0);
    check("arst.state",       16'(bus.state), 16'd0);
    check("arst.stall_cnt",   bus.stall_cnt, 16'd0);
    #0.5;
    rst_n = 1'b1;
    m_mode = 0;
    m_cnt  = 0;
    idle_inputs();
    step("arst_after");

    // r0 never creates a dependency, even against a load to r0.
    bus.ex_rd = 0; bus.ex_reg_write = 1; bus.ex_mem_read = 1;
    bus.id_rs1 = 0; bus.id_use_rs1 = 1;
    step("r0_load");
    idle_inputs();

    // Random traffic over a small register range so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      bus.id_rs1          = 5'($urandom_range(0, 3));
      bus.id_rs2          = 5'($urandom_range(0, 3));
      bus.id_use_rs1      = 1'($urandom_range(0, 1));
      bus.id_use_rs2      = 1'($urandom_range(0, 1));
      bus.ex_rd           = 5'($urandom_range(0, 3));
      bus.ex_reg_write    = 1'($urandom_range(0, 1));
      bus.ex_mem_read     = 1'($urandom_range(0, 1));
      bus.mem_rd          = 5'($urandom_range(0, 3));
      bus.mem_reg_write   = 1'($urandom_range(0, 1));
      bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
      bus.ex_mc_start     = ($urandom_range(0, 7) == 0);
      bus.mc_done         = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
